// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: ALU op codes, the legality
// check for op codes and the scheduler FSM encoding.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at ptr
// and returns the first requester found, as a one-hot grant and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    // One spare bit so ptr + offset cannot overflow before the modulo fold.
    logic [IDX_W:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_any && req[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        grant[grant_idx] = grant_any;
    end

endmodule

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one external combinational ALU between NUM_REQ
// requesters; one op in flight at a time, response held until its owner accepts.
module alu_req_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [7:0]           rsp_y,
    output logic                 rsp_zero,
    output logic                 rsp_negative,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_ctrl,
    input  logic [7:0]           alu_y,
    input  logic                 alu_zero,
    input  logic                 alu_negative,
    input  logic                 alu_carry,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [7:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]         alu_ctrl_q, alu_ctrl_d;
    logic [7:0]         rsp_y_q, rsp_y_d;
    logic               rsp_zero_q, rsp_zero_d, rsp_neg_q, rsp_neg_d;
    logic               rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] owner_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
        assign owner_onehot[gi] = (owner_q == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready[owner_q]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // req_ready is gated by rst_n so a held request is never shown as accepted while in reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == ST_IDLE && rst_n) req_ready = grant;
        if (state_q == ST_RESP)          rsp_valid = owner_onehot;
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_y_d     = rsp_y_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_neg_d   = rsp_neg_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    owner_d    = grant_idx;
                    alu_a_d    = req_a[grant_idx*8 +: 8];
                    alu_b_d    = req_b[grant_idx*8 +: 8];
                    alu_ctrl_d = req_op[grant_idx*3 +: 3];
                    rr_ptr_d   = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
                end
            end
            ST_EXEC: begin
                rsp_y_d     = alu_y;
                rsp_zero_d  = alu_zero;
                rsp_neg_d   = alu_negative;
                rsp_carry_d = alu_carry;
                rsp_err_d   = !op_is_legal(alu_ctrl_q);
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) op_count_d = op_count_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            rsp_y_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_neg_q   <= rsp_neg_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_negative = rsp_neg_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_err      = rsp_err_q;
    assign op_count     = op_count_q;

endmodule
